// File: rtl/uart_pkt_tx_if.sv
// uart_pkt_tx_if: result-word handshake and UART status bundle for uart_pkt_tx
interface uart_pkt_tx_if #(
  parameter int DATA_W = 22
) ();
  logic              stream_en;
  logic              data_rdy;
  logic [DATA_W-1:0] data_led1;
  logic [DATA_W-1:0] data_led2;
  logic              tx;
  logic              busy;
  logic              pkt_done;
  logic [7:0]        drop_cnt;
  modport master (
    output stream_en, data_rdy, data_led1, data_led2,
    input  tx, busy, pkt_done, drop_cnt
  );
  modport slave (
    input  stream_en, data_rdy, data_led1, data_led2,
    output tx, busy, pkt_done, drop_cnt
  );
endinterface

// File: rtl/uart_pkt_tx.sv
// uart_pkt_tx: frames two result words into an 8-byte packet and sends it as 8N1 UART
module uart_pkt_tx #(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] HEADER       = 8'hAA,
  parameter int         DATA_W       = 22
) (
  input logic          clk,
  input logic          reset_n,
  uart_pkt_tx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t            state, state_n;
  logic [15:0]       baud_cnt;
  logic [2:0]        bit_idx, byte_idx;
  logic [DATA_W-1:0] raw1, raw2;
  logic [23:0]       in1, in2, cur1, cur2, pend1, pend2;
  logic              pend_v, accept, busy_i, baud_last, pkt_end;
  logic              load_pend, load_new, cap_pend, drop;
  logic [7:0]        csum, cur_byte, drop_cnt;
  logic [63:0]       pkt;
  logic              tx;
  assign raw1 = bus.data_led1;
  assign raw2 = bus.data_led2;
  assign in1  = 24'(raw1);
  assign in2  = 24'(raw2);
  always_comb begin
    accept    = bus.data_rdy && bus.stream_en;
    busy_i    = state != IDLE;
    baud_last = baud_cnt == 16'(CLKS_PER_BIT - 1);
    pkt_end   = state == STOP && baud_last && byte_idx == 3'd7;
    load_pend = pkt_end && pend_v && bus.stream_en;
    load_new  = accept && (state == IDLE || (pkt_end && !pend_v));
    cap_pend  = accept && busy_i && !pkt_end && !pend_v;
    drop      = accept && busy_i && pend_v;
    csum      = cur1[23:16] ^ cur1[15:8] ^ cur1[7:0] ^ cur2[23:16] ^ cur2[15:8] ^ cur2[7:0];
    pkt       = {HEADER, cur1, cur2, csum};
    cur_byte  = pkt[{~byte_idx, 3'b000} +: 8];
    tx        = state == START ? 1'b0 : state == DATA ? cur_byte[bit_idx] : 1'b1;
    state_n   = state == IDLE ? (accept ? START : IDLE) :
                !baud_last    ? state :
                state == START ? DATA :
                state == DATA  ? (bit_idx == 3'd7 ? STOP : DATA) :
                (byte_idx != 3'd7 || load_pend || load_new) ? START : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      cur1     <= '0;
      cur2     <= '0;
      pend1    <= '0;
      pend2    <= '0;
      pend_v   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      baud_cnt <= (!busy_i || baud_last) ? '0 : baud_cnt + 16'd1;
      bit_idx  <= !busy_i ? '0 : (state == DATA && baud_last) ? bit_idx + 3'd1 : bit_idx;
      byte_idx <= !busy_i ? '0 : (state == STOP && baud_last) ? byte_idx + 3'd1 : byte_idx;
      if (load_pend) {cur1, cur2} <= {pend1, pend2};
      else if (load_new) {cur1, cur2} <= {in1, in2};
      if (cap_pend) {pend1, pend2} <= {in1, in2};
      pend_v <= (load_pend || !bus.stream_en) ? 1'b0 : cap_pend ? 1'b1 : pend_v;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
  assign bus.tx       = tx;
  assign bus.busy     = busy_i;
  assign bus.pkt_done = pkt_end;
  assign bus.drop_cnt = drop_cnt;
endmodule

// File: tb/tb_uart_pkt_tx.sv
// tb_uart_pkt_tx: directed self-checking bench for uart_pkt_tx at 4 clocks per bit
module tb_uart_pkt_tx;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;
  localparam logic [63:0] PKT_A = 64'hAA0123453ABCDE3F;
  localparam logic [63:0] PKT_B = 64'hAA00000100000203;
  localparam logic [63:0] PKT_C = 64'hAA000111000222_30;
  localparam logic [63:0] PKT_D = 64'hAA0ABCDE155555_7D;
  localparam logic [63:0] PKT_G = 64'hAA123456000000_70;
  uart_pkt_tx_if #(.DATA_W(22)) bus ();
  uart_pkt_tx #(.CLKS_PER_BIT(4), .HEADER(8'hAA), .DATA_W(22)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic strobe(input logic [21:0] a, input logic [21:0] b);
    bus.data_led1 = a;
    bus.data_led2 = b;
    bus.data_rdy  = 1'b1;
    @(negedge clk);
    bus.data_rdy  = 1'b0;
    bus.data_led1 = ~a;
    bus.data_led2 = ~b;
  endtask
  task automatic cap_pkt(output logic [63:0] pkt, output int done_at, output int ferr);
    logic [319:0] txs, pds;
    for (int i = 0; i < 320; i++) begin
      txs[i] = bus.tx;
      pds[i] = bus.pkt_done;
      @(negedge clk);
    end
    pkt = '0;
    ferr = 0;
    done_at = -1;
    for (int i = 319; i >= 0; i--) if (pds[i]) done_at = i;
    for (int j = 0; j < 8; j++) begin
      if (txs[40*j+2] !== 1'b0) ferr++;
      if (txs[40*j+38] !== 1'b1) ferr++;
      for (int b = 0; b < 8; b++) pkt[8*(7-j)+b] = txs[40*j+4+4*b+2];
    end
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.pkt_done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus.pkt_done, 1);
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus.busy, 0);
  endtask
  task automatic idle_window(input string tag);
    int act = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy !== 1'b0 || bus.tx !== 1'b1) act++;
      @(negedge clk);
    end
    check(tag, act, 0);
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [63:0] p1, p2;
    int d1, d2, f1, f2;
    bus.stream_en = 1'b1;
    bus.data_rdy  = 1'b0;
    bus.data_led1 = '0;
    bus.data_led2 = '0;
    repeat (2) @(negedge clk);
    check("rst_tx", bus.tx, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_pkt_done", bus.pkt_done, 0);
    check("rst_drop", bus.drop_cnt, 0);
    reset_n = 1'b1;
    @(negedge clk);
    strobe(22'h012345, 22'h3ABCDE);
    check("single_tx_fall", bus.tx, 0);
    check("single_busy", bus.busy, 1);
    cap_pkt(p1, d1, f1);
    check("single_bytes", p1, PKT_A);
    check("single_done_cycle", d1, 319);
    check("single_framing", f1, 0);
    check("single_busy_drop", bus.busy, 0);
    check("single_tx_idle", bus.tx, 1);
    strobe(22'h012345, 22'h3ABCDE);
    fork
      cap_pkt(p1, d1, f1);
      begin
        repeat (50) @(negedge clk);
        strobe(22'h000001, 22'h000002);
      end
    join
    check("b2b_pkt1", p1, PKT_A);
    check("b2b_no_gap", bus.tx, 0);
    cap_pkt(p2, d2, f2);
    check("b2b_pkt2", p2, PKT_B);
    check("b2b_framing", f2, 0);
    check("b2b_drop", bus.drop_cnt, 0);
    check("b2b_idle", bus.busy, 0);
    strobe(22'h000111, 22'h000222);
    fork
      cap_pkt(p1, d1, f1);
      begin
        repeat (20) @(negedge clk);
        strobe(22'h0ABCDE, 22'h155555);
        repeat (20) @(negedge clk);
        strobe(22'h3FFFFF, 22'h000000);
      end
    join
    check("ovf_pkt1", p1, PKT_C);
    check("ovf_next_start", bus.tx, 0);
    cap_pkt(p2, d2, f2);
    check("ovf_pkt2", p2, PKT_D);
    check("ovf_drop", bus.drop_cnt, 1);
    check("ovf_idle", bus.busy, 0);
    strobe(22'h000111, 22'h000222);
    bus.data_led1 = 22'h0ABCDE;
    bus.data_led2 = 22'h155555;
    bus.data_rdy  = 1'b1;
    repeat (301) @(negedge clk);
    bus.data_rdy  = 1'b0;
    check("sat_drop", bus.drop_cnt, 255);
    wait_idle("sat_drain");
    check("sat_hold", bus.drop_cnt, 255);
    do_reset();
    check("rst2_drop", bus.drop_cnt, 0);
    strobe(22'h000001, 22'h000002);
    wait_done("bnd_done_empty");
    strobe(22'h2AAAAA, 22'h155555);
    check("bnd_empty_start", bus.tx, 0);
    check("bnd_empty_drop", bus.drop_cnt, 0);
    repeat (30) @(negedge clk);
    strobe(22'h123456, 22'h000000);
    wait_done("bnd_done_full");
    strobe(22'h3FFFFF, 22'h3FFFFF);
    check("bnd_full_start", bus.tx, 0);
    check("bnd_full_drop", bus.drop_cnt, 1);
    cap_pkt(p1, d1, f1);
    check("bnd_full_pkt", p1, PKT_G);
    check("bnd_full_idle", bus.busy, 0);
    strobe(22'h012345, 22'h3ABCDE);
    fork
      cap_pkt(p1, d1, f1);
      begin
        repeat (20) @(negedge clk);
        strobe(22'h0ABCDE, 22'h155555);
        repeat (109) @(negedge clk);
        bus.stream_en = 1'b0;
      end
    join
    check("stop_pkt", p1, PKT_A);
    check("stop_idle", bus.busy, 0);
    check("stop_tx", bus.tx, 1);
    check("stop_drop", bus.drop_cnt, 1);
    strobe(22'h000001, 22'h000002);
    strobe(22'h000003, 22'h000004);
    idle_window("stop_ignore");
    check("stop_ignore_drop", bus.drop_cnt, 1);
    bus.stream_en = 1'b1;
    strobe(22'h012345, 22'h3ABCDE);
    repeat (20) @(negedge clk);
    strobe(22'h0ABCDE, 22'h155555);
    repeat (189) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("rstmid_tx", bus.tx, 1);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_drop", bus.drop_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    idle_window("rstmid_pend_clr");
    strobe(22'h123456, 22'h000000);
    check("rstmid_restart", bus.tx, 0);
    cap_pkt(p1, d1, f1);
    check("rstmid_pkt", p1, PKT_G);
    check("rstmid_framing", f1, 0);
    check("rstmid_idle", bus.busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
